bic_tx_framer: RTL

Parametrised serial transmit framer for the bi-directional chat link. It accepts a parallel character over a request/acknowledge handshake and serialises it onto the line as a full frame: start bit, LSB-first data, optional even parity, then 1–2 stop bits. Bit timing comes from an external baud strobe. It reports per-bit progress and pulses `char_sent` once per completed frame. It sits between the character source (keyboard/UI logic) and the line driver, and replaces the fixed 8-bit transmit counter.

---
 rtl/bic_pkg.sv | 33 +++
 rtl/bic_tx_shreg.sv | 39 +++
 rtl/bic_tx_framer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bic_pkg.sv
// bic_pkg: definitions shared by the bi-directional chat link transmit and
// receive paths.
//   - tx_state_t      : transmit framer state encoding
//   - BIC_IDLE_LEVEL  : level the serial line rests at between frames
//   - BIC_DATA_BITS / BIC_STOP_BITS : default frame geometry
//   - bic_even_parity : even-parity helper (only with BIC_TX_PARITY_EN)
// Optional feature macro: BIC_TX_PARITY_EN (adds the PAR state and helper).
package bic_pkg;

    localparam int   BIC_DATA_BITS  = 8;
    localparam int   BIC_STOP_BITS  = 1;
    localparam logic BIC_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_ARM   = 3'd1,
        TX_START = 3'd2,
        TX_DATA  = 3'd3,
`ifdef BIC_TX_PARITY_EN
        TX_PAR   = 3'd4,
`endif
        TX_STOP  = 3'd5
    } tx_state_t;

`ifdef BIC_TX_PARITY_EN
    // Even parity over a zero-extended character (zero padding does not
    // change the XOR, so any DATA_BITS up to 16 can use it).
    function automatic logic bic_even_parity(input logic [15:0] data);
        return ^data;
    endfunction
`endif

endpackage

// File: rtl/bic_tx_shreg.sv
// bic_tx_shreg: DATA_BITS-wide load / shift-right register holding the
// character being serialised.
// Ports:
//   clk, rst (async, active-low)
//   load  : capture din (has priority over shift)
//   shift : shift right by one, zero filling from the top
//   din   : parallel character
//   lsb   : bit currently at position 0
module bic_tx_shreg
    import bic_pkg::*;
#(
    parameter int DATA_BITS = BIC_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [DATA_BITS-1:0] din,
    output logic                 lsb
);

    logic [DATA_BITS-1:0] shreg_r;

    // Character storage: load on acceptance, shift once per data bit sent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r <= '0;
        end else if (load) begin
            shreg_r <= din;
        end else if (shift) begin
            shreg_r <= {1'b0, shreg_r[DATA_BITS-1:1]};
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign lsb = shreg_r[0];

endmodule

// File: rtl/bic_tx_framer.sv
// bic_tx_framer: serial transmit framer for the chat link.
// Accepts a character over tx_req/tx_ack and sends start bit, LSB-first data,
// optional even parity and STOP_BITS stop bits, one bit per bit_tick.
// Ports:
//   clk, rst (async, active-low), bit_tick (baud strobe)
//   tx_req / tx_data / tx_ack : character handshake (tx_ack one-cycle pulse)
//   tx_out    : serial line, idles high
//   busy      : acceptance through frame completion
//   bit_idx   : index of data bit on the line, 0 outside DATA
//   char_sent : one-cycle pulse when the frame completes
// Optional feature macro: BIC_TX_PARITY_EN (even-parity bit after the data).
module bic_tx_framer
    import bic_pkg::*;
#(
    parameter int DATA_BITS = BIC_DATA_BITS,
    parameter int STOP_BITS = BIC_STOP_BITS,
    parameter int IDX_W     = $clog2(DATA_BITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_tick,
    input  logic                 tx_req,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ack,
    output logic                 tx_out,
    output logic                 busy,
    output logic [IDX_W-1:0]     bit_idx,
    output logic                 char_sent
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    // Stop counter only needs one bit since at most two stop bits exist.
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t        state_r, state_nxt_s;
    logic [IDX_W-1:0] bit_idx_r, bit_idx_nxt_s;
    logic             stop_cnt_r, stop_cnt_nxt_s;
    logic             tx_out_r, tx_out_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             tx_ack_r, tx_ack_nxt_s;
    logic             char_sent_r, char_sent_nxt_s;
    logic             load_s, shift_s, lsb_s;

    bic_tx_shreg #(.DATA_BITS(DATA_BITS)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .shift (shift_s),
        .din   (tx_data),
        .lsb   (lsb_s)
    );

`ifdef BIC_TX_PARITY_EN
    logic parity_r;

    // Parity is captured with the character so PAR needs no extra shifting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_r <= 1'b0;
        end else if (load_s) begin
            parity_r <= bic_even_parity(16'(tx_data));
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    // State and all outputs are registered; a reset returns the line to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= TX_IDLE;
            bit_idx_r   <= '0;
            stop_cnt_r  <= 1'b0;
            tx_out_r    <= BIC_IDLE_LEVEL;
            busy_r      <= 1'b0;
            tx_ack_r    <= 1'b0;
            char_sent_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bit_idx_r   <= bit_idx_nxt_s;
            stop_cnt_r  <= stop_cnt_nxt_s;
            tx_out_r    <= tx_out_nxt_s;
            busy_r      <= busy_nxt_s;
            tx_ack_r    <= tx_ack_nxt_s;
            char_sent_r <= char_sent_nxt_s;
        end
    end

    // Next-state and next-output decode. The value driven on tx_out is chosen
    // on the tick that starts each bit, so every bit lasts one tick period.
    always_comb begin
        state_nxt_s     = state_r;
        bit_idx_nxt_s   = bit_idx_r;
        stop_cnt_nxt_s  = stop_cnt_r;
        tx_out_nxt_s    = tx_out_r;
        busy_nxt_s      = busy_r;
        tx_ack_nxt_s    = 1'b0;
        char_sent_nxt_s = 1'b0;
        load_s          = 1'b0;
        shift_s         = 1'b0;
        case (state_r)
            TX_IDLE: begin
                tx_out_nxt_s  = BIC_IDLE_LEVEL;
                bit_idx_nxt_s = '0;
                if (tx_req) begin
                    state_nxt_s  = TX_ARM;
                    load_s       = 1'b1;
                    tx_ack_nxt_s = 1'b1;
                    busy_nxt_s   = 1'b1;
                end else begin
                    busy_nxt_s   = 1'b0;
                end
            end
            // ARM waits for a fresh tick so the start bit is full length.
            TX_ARM: begin
                if (bit_tick) begin
                    state_nxt_s  = TX_START;
                    tx_out_nxt_s = 1'b0;
                end else begin
                    state_nxt_s  = TX_ARM;
                end
            end
            // Driving a bit and shifting together keeps the next bit at lsb.
            TX_START: begin
                if (bit_tick) begin
                    state_nxt_s   = TX_DATA;
                    tx_out_nxt_s  = lsb_s;
                    shift_s       = 1'b1;
                    bit_idx_nxt_s = '0;
                end else begin
                    state_nxt_s   = TX_START;
                end
            end
            TX_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_r == LAST_IDX) begin
                        bit_idx_nxt_s  = '0;
`ifdef BIC_TX_PARITY_EN
                        state_nxt_s    = TX_PAR;
                        tx_out_nxt_s   = parity_r;
`else
                        state_nxt_s    = TX_STOP;
                        tx_out_nxt_s   = BIC_IDLE_LEVEL;
                        stop_cnt_nxt_s = 1'b0;
`endif
                    end else begin
                        bit_idx_nxt_s  = bit_idx_r + IDX_W'(1);
                        tx_out_nxt_s   = lsb_s;
                        shift_s        = 1'b1;
                    end
                end else begin
                    state_nxt_s = TX_DATA;
                end
            end
`ifdef BIC_TX_PARITY_EN
            TX_PAR: begin
                if (bit_tick) begin
                    state_nxt_s    = TX_STOP;
                    tx_out_nxt_s   = BIC_IDLE_LEVEL;
                    stop_cnt_nxt_s = 1'b0;
                end else begin
                    state_nxt_s    = TX_PAR;
                end
            end
`endif
            TX_STOP: begin
                tx_out_nxt_s = BIC_IDLE_LEVEL;
                if (bit_tick) begin
                    if (stop_cnt_r == STOP_LAST) begin
                        state_nxt_s     = TX_IDLE;
                        char_sent_nxt_s = 1'b1;
                        busy_nxt_s      = 1'b0;
                        stop_cnt_nxt_s  = 1'b0;
                    end else begin
                        stop_cnt_nxt_s  = stop_cnt_r + 1'b1;
                    end
                end else begin
                    state_nxt_s = TX_STOP;
                end
            end
            default: begin
                state_nxt_s    = TX_IDLE;
                bit_idx_nxt_s  = '0;
                stop_cnt_nxt_s = 1'b0;
                tx_out_nxt_s   = BIC_IDLE_LEVEL;
                busy_nxt_s     = 1'b0;
            end
        endcase
    end

    assign tx_ack    = tx_ack_r;
    assign tx_out    = tx_out_r;
    assign busy      = busy_r;
    assign bit_idx   = bit_idx_r;
    assign char_sent = char_sent_r;

endmodule
